accumulator_arbiter: RTL
========================

# accumulator_arbiter

Shares one `accumulator` instance between several ballot sources, each supplying whole NUM_BITS_STORED-bit numbers as REGISTER_SIZE-bit chunks, least-significant chunk first. Grants one requester per number, forwards its chunks, and counts chunks retired by the accumulator. Holds off the next grant until the previous number is fully written back. It sits between the per-voter encryption pipelines and the tally accumulator.

## Interface
- REGISTER_SIZE, 32, chunk width; must match the accumulator.
- NUM_BITS_STORED, 2048, number width; must be a multiple of REGISTER_SIZE.
- NUM_REQUESTERS, 4, number of sources; 2..16.
- MAX_NUMBERS, 1024, numbers accepted before full_out asserts.
- Clocking and reset (decided): one clock; reset is asynchronous and active-high.
- clk_in  in  1  sole clock.
- rst_in  in  1  asynchronous, active-high reset.
- req_in  in  NUM_REQUESTERS  requester i has a complete number ready.
- block_in  in  NUM_REQUESTERS*REGISTER_SIZE  flat chunk buses; requester i occupies bits [i*REGISTER_SIZE +: REGISTER_SIZE].
- valid_in  in  NUM_REQUESTERS  chunk valid per requester.
- grant_out  out  NUM_REQUESTERS  one-hot grant; registered.
- ready_out  out  NUM_REQUESTERS  chunk accepted this cycle when valid_in[i] is also high.
- acc_ready_in  in  1  accumulator ready_out.
- acc_valid_back_in  in  1  accumulator valid_out; one pulse per retired chunk.
- acc_block_out  out  REGISTER_SIZE  to accumulator block_in.
- acc_valid_out  out  1  to accumulator valid_in.
- number_done_out  out  1  one-cycle pulse when the last chunk of a number retires.
- count_out  out  $clog2(MAX_NUMBERS+1)  numbers fully accumulated.
- full_out  out  1  count_out == MAX_NUMBERS.
- abort_out  out  1  one-cycle pulse when a transfer is aborted.

## Operation
- BLOCKS = NUM_BITS_STORED/REGISTER_SIZE.
- States:
  - WAIT_ACC: entered on reset.
  - ARB: waits for a request.
  - XFER: forwards chunks.
  - DRAIN: waits for writeback.
- WAIT_ACC -> ARB when acc_ready_in = 1.
- ARB: if any req_in bit is set and full_out = 0, latch the winner into grant_out and go to XFER. Otherwise stay in ARB.
- In XFER:
  - ready_out[i] = grant_out[i] & acc_ready_in.
  - acc_valid_out = valid_in[g] & ready_out[g], where g is the granted index.
  - acc_block_out = the granted requester's chunk.
  - sent_cnt increments on each acc_valid_out.
  - When sent_cnt reaches BLOCKS: clear grant_out and go to DRAIN.
- In DRAIN, ret_cnt increments on acc_valid_back_in. When ret_cnt reaches BLOCKS:
  - pulse number_done_out;
  - increment count_out;
  - clear both counters;
  - go to ARB.
- req_in is sampled only in ARB. Deasserting req mid-XFER has no effect; the grant is held for BLOCKS chunks.
- acc_ready_in falling in XFER or DRAIN (accumulator reset or cleaning):
  - pulse abort_out;
  - clear grant_out, both counters and count_out;
  - go to WAIT_ACC.
- Valid chunks from non-granted requesters are ignored. Their ready_out stays 0.
- Once count_out reaches MAX_NUMBERS, full_out = 1 and no further grants are issued. count_out never wraps.

## Timing
- Reset values: grant_out = 0, ready_out = 0, acc_valid_out = 0, acc_block_out = 0, number_done_out = 0, count_out = 0, full_out = 0, abort_out = 0. State is WAIT_ACC.
- Request-to-grant latency: one cycle. Request sampled in ARB at edge n; grant_out visible after edge n+1.
- ready_out, acc_valid_out and acc_block_out are combinational from grant, valid_in and acc_ready_in. Zero added latency into the accumulator.
- The accumulator retires a chunk 2 cycles after acceptance. Minimum turnaround from last chunk accepted to next grant: 3 cycles.
- Number i+1 is never granted before number i's final writeback.
- number_done_out and the count_out increment occur in the same cycle.
- Reset mid-operation: asynchronous clear to the reset values above, regardless of state.

## Configuration
- ACC_ARB_ROUND_ROBIN_EN defined: round-robin arbitration. The priority pointer moves to (winner+1) mod NUM_REQUESTERS after each grant.
- Undefined: fixed priority; the lowest requester index wins.

## Structure
- Shared package acc_pkg holds:
  - the state enum acc_arb_state_t;
  - the BLOCKS computation as a localparam function of REGISTER_SIZE and NUM_BITS_STORED, also used by the accumulator.
- One sub-module, rr_arbiter: req vector plus update strobe in, one-hot grant out. Its pointer logic is compiled only under ACC_ARB_ROUND_ROBIN_EN.

## Test plan
- Single source: reset, acc_ready_in rises at cycle 64, req_in = 0001 with 64 back-to-back chunks of value 1 -> grant_out = 0001 one cycle after ARB; 64 acc_valid_out; number_done_out 2 cycles after the last chunk; count_out = 1.
- Contention: req_in = 1111 held, with and without ACC_ARB_ROUND_ROBIN_EN.
  - Round-robin grant order: 0, 1, 2, 3, 0.
  - Fixed priority grant order: 0, 0, 0.
  - In both cases, no grant is issued before the prior number_done_out.
- Stalls: granted source toggles valid_in every other cycle -> sent_cnt and acc_valid_out track only accepted chunks; exactly 64 forwarded; other sources' ready_out stays 0.
- Abort: drop acc_ready_in after 10 chunks -> abort_out pulse; grant_out = 0; count_out = 0; state returns to WAIT_ACC; resumes when acc_ready_in rises.
- Saturation: MAX_NUMBERS = 2, three requests -> count_out = 2, full_out = 1, third request never granted.
- Async reset asserted mid-XFER between clock edges -> all outputs reach reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared types and chunk-count helper for the tally accumulator and its arbiter
//
// Contents:
//   acc_arb_state_t : arbiter FSM states
//   calc_blocks()   : chunks per stored number (NUM_BITS_STORED / REGISTER_SIZE)
package acc_pkg;

    typedef enum logic [1:0] {
        WAIT_ACC = 2'd0,
        ARB      = 2'd1,
        XFER     = 2'd2,
        DRAIN    = 2'd3
    } acc_arb_state_t;

    function automatic int calc_blocks(input int num_bits_stored, input int register_size);
        return num_bits_stored / register_size;
    endfunction

    localparam int DEFAULT_REGISTER_SIZE   = 32;
    localparam int DEFAULT_NUM_BITS_STORED = 2048;
    localparam int DEFAULT_BLOCKS          = calc_blocks(DEFAULT_NUM_BITS_STORED, DEFAULT_REGISTER_SIZE);

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - request vector to one-hot grant, round-robin or fixed priority
//
// Macro: ACC_ARB_ROUND_ROBIN_EN selects round-robin; otherwise lowest index wins.
// Ports:
//   clk_in, rst_in : clock, asynchronous active-high reset (pointer only)
//   req_in         : request vector
//   update_in      : strobe, the current grant was taken; advance pointer
//   grant_out      : one-hot (or zero) combinational grant
module rr_arbiter
    import acc_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic [N-1:0] req_in,
    input  logic         update_in,
    output logic [N-1:0] grant_out
);

`ifdef ACC_ARB_ROUND_ROBIN_EN
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;
    int            idx;

    // Scan from the pointer upward, wrapping; first requester found wins.
    always_comb begin
        grant_out = '0;
        ptr_d     = ptr_q;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!found && req_in[idx]) begin
                grant_out[idx] = 1'b1;
                ptr_d          = PW'((idx + 1) % N);
                found          = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ptr_q <= '0;
        end else if (update_in) begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Isolate the lowest set bit.
    assign grant_out = req_in & (~req_in + N'(1));

    logic unused_rr;
    assign unused_rr = ^{clk_in, rst_in, update_in};
`endif

endmodule

// File: rtl/accumulator_arbiter.sv
// rtl/accumulator_arbiter.sv - shares one accumulator between several chunked-number sources
//
// Macro: ACC_ARB_ROUND_ROBIN_EN selects round-robin arbitration (default fixed priority).
// Ports:
//   clk_in, rst_in      : clock, asynchronous active-high reset
//   req_in              : per-source "complete number ready"
//   block_in, valid_in  : per-source chunk bus (flat, source i at [i*REGISTER_SIZE +: REGISTER_SIZE])
//   grant_out           : registered one-hot grant
//   ready_out           : per-source chunk accept
//   acc_ready_in        : accumulator ready; low during XFER/DRAIN aborts the transfer
//   acc_valid_back_in   : accumulator retire pulse, one per chunk
//   acc_block_out/acc_valid_out : chunk stream into the accumulator
//   number_done_out     : pulse when a number's last chunk retires
//   count_out, full_out : numbers accumulated, saturation flag
//   abort_out           : pulse on transfer abort
module accumulator_arbiter
    import acc_pkg::*;
#(
    parameter int REGISTER_SIZE   = 32,
    parameter int NUM_BITS_STORED = 2048,
    parameter int NUM_REQUESTERS  = 4,
    parameter int MAX_NUMBERS     = 1024
) (
    input  logic                                     clk_in,
    input  logic                                     rst_in,
    input  logic [NUM_REQUESTERS-1:0]                req_in,
    input  logic [NUM_REQUESTERS*REGISTER_SIZE-1:0]  block_in,
    input  logic [NUM_REQUESTERS-1:0]                valid_in,
    output logic [NUM_REQUESTERS-1:0]                grant_out,
    output logic [NUM_REQUESTERS-1:0]                ready_out,
    input  logic                                     acc_ready_in,
    input  logic                                     acc_valid_back_in,
    output logic [REGISTER_SIZE-1:0]                 acc_block_out,
    output logic                                     acc_valid_out,
    output logic                                     number_done_out,
    output logic [$clog2(MAX_NUMBERS+1)-1:0]         count_out,
    output logic                                     full_out,
    output logic                                     abort_out
);

    localparam int BLOCKS  = calc_blocks(NUM_BITS_STORED, REGISTER_SIZE);
    localparam int CNT_W   = $clog2(BLOCKS + 1);
    localparam int COUNT_W = $clog2(MAX_NUMBERS + 1);

    acc_arb_state_t              state_q, state_d;
    logic [NUM_REQUESTERS-1:0]   grant_q, grant_d, arb_grant;
    logic [CNT_W-1:0]            sent_q, sent_d, ret_q, ret_d;
    logic [COUNT_W-1:0]          count_q, count_d;
    logic                        done_q, done_d, abort_q, abort_d;
    logic                        full, take_grant, chunk_fire, last_sent, last_ret, abort_cond;

    assign full       = (count_q == COUNT_W'(MAX_NUMBERS));
    assign take_grant = (state_q == ARB) && (|req_in) && !full;
    assign chunk_fire = acc_valid_out;
    assign last_sent  = chunk_fire && (sent_q == CNT_W'(BLOCKS - 1));
    assign last_ret   = (state_q == DRAIN) && acc_valid_back_in && (ret_q == CNT_W'(BLOCKS - 1));
    // Accumulator dropping ready mid-number means it is being reset or cleaned.
    assign abort_cond = ((state_q == XFER) || (state_q == DRAIN)) && !acc_ready_in;

    rr_arbiter #(
        .N(NUM_REQUESTERS)
    ) u_rr_arbiter (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .req_in    (req_in),
        .update_in (take_grant),
        .grant_out (arb_grant)
    );

    // FSM: state register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= WAIT_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_ACC: if (acc_ready_in) state_d = ARB;
            ARB:      if (take_grant)   state_d = XFER;
            XFER: begin
                if (abort_cond)     state_d = WAIT_ACC;
                else if (last_sent) state_d = DRAIN;
            end
            DRAIN: begin
                if (abort_cond)     state_d = WAIT_ACC;
                else if (last_ret)  state_d = ARB;
            end
            default:                state_d = WAIT_ACC;
        endcase
    end

    // FSM: outputs (combinational path from grant/valid/ready into the accumulator)
    always_comb begin
        ready_out     = '0;
        acc_valid_out = 1'b0;
        acc_block_out = '0;
        if (state_q == XFER) begin
            ready_out = grant_q & {NUM_REQUESTERS{acc_ready_in}};
            for (int i = 0; i < NUM_REQUESTERS; i++) begin
                if (grant_q[i]) acc_block_out = block_in[i*REGISTER_SIZE +: REGISTER_SIZE];
            end
            acc_valid_out = |(valid_in & ready_out);
        end
    end

    // Datapath next state: grant, chunk counters, number count, pulses
    always_comb begin
        grant_d = grant_q;
        sent_d  = sent_q;
        ret_d   = ret_q;
        count_d = count_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        if (abort_cond) begin
            grant_d = '0;
            sent_d  = '0;
            ret_d   = '0;
            count_d = '0;
            abort_d = 1'b1;
        end else begin
            case (state_q)
                ARB: begin
                    if (take_grant) grant_d = arb_grant;
                end
                XFER: begin
                    if (chunk_fire)        sent_d  = sent_q + CNT_W'(1);
                    if (last_sent)         grant_d = '0;
                    // Early chunks retire while later ones are still being sent.
                    if (acc_valid_back_in) ret_d   = ret_q + CNT_W'(1);
                end
                DRAIN: begin
                    if (last_ret) begin
                        done_d = 1'b1;
                        sent_d = '0;
                        ret_d  = '0;
                        if (!full) count_d = count_q + COUNT_W'(1);
                    end else if (acc_valid_back_in) begin
                        ret_d = ret_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            grant_q <= '0;
            sent_q  <= '0;
            ret_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            grant_q <= grant_d;
            sent_q  <= sent_d;
            ret_q   <= ret_d;
            count_q <= count_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    assign grant_out       = grant_q;
    assign number_done_out = done_q;
    assign abort_out       = abort_q;
    assign count_out       = count_q;
    assign full_out        = full;

endmodule
